// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with prioritised redirects, EPC and a
// pending-redirect buffer that holds a redirect raised during a stall.
module pc_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [WIDTH-1:0] IMEM_BASE = 32'h0000_3000,
  parameter int IMEM_BYTES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_stall,
  input  logic i_br_taken,
  input  logic [WIDTH-1:0] i_br_target,
  input  logic i_jump,
  input  logic [WIDTH-1:0] i_jump_target,
  input  logic i_exc,
  input  logic [WIDTH-1:0] i_epc_in,
  input  logic i_eret,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic [WIDTH-1:0] o_epc,
  output logic o_redirect_pending,
  output logic o_fetch_err
);
  localparam logic [WIDTH:0] LIMIT = {1'b0, IMEM_BASE} + (WIDTH+1)'(IMEM_BYTES);
  logic [WIDTH-1:0] r_pc, r_epc, r_pend_tgt, w_live_tgt, w_next_pc;
  logic [1:0] r_pend_code, w_live_code;
  logic w_live_wins;
  // redirect codes rank by priority: 3 eret, 2 jump, 1 branch, 0 none
  assign w_live_code = i_eret ? 2'd3 : i_jump ? 2'd2 : i_br_taken ? 2'd1 : 2'd0;
  assign w_live_tgt = i_eret ? r_epc : i_jump ? i_jump_target : i_br_target;
  assign w_live_wins = (w_live_code != 2'd0) && (w_live_code >= r_pend_code);
  assign w_next_pc = w_live_wins ? w_live_tgt : (r_pend_code != 2'd0) ? r_pend_tgt : o_pc_plus4;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_VECTOR;
      r_epc <= '0;
      r_pend_code <= 2'd0;
      r_pend_tgt <= '0;
    end else if (i_exc) begin
      r_pc <= EXC_VECTOR;
      r_epc <= {i_epc_in[WIDTH-1:2], 2'b00};
      r_pend_code <= 2'd0;
    end else if (i_stall) begin
      if (w_live_wins) begin
        r_pend_code <= w_live_code;
        r_pend_tgt <= w_live_tgt;
      end
    end else begin
      r_pc <= w_next_pc;
      r_pend_code <= 2'd0;
    end
  end
  assign o_pc = r_pc;
  assign o_pc_plus4 = r_pc + WIDTH'(4);
  assign o_epc = r_epc;
  assign o_redirect_pending = r_pend_code != 2'd0;
  assign o_fetch_err = (r_pc[1:0] != 2'b00) || (r_pc < IMEM_BASE) || ({1'b0, r_pc} >= LIMIT);
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed, self-checking bench for pc_unit.
module tb_pc_unit;
  logic clk = 0, rst_n = 0;
  logic stall = 0, br = 0, jmp = 0, exc = 0, eret = 0;
  logic [31:0] br_t = 0, jmp_t = 0, epc_in = 0;
  logic [31:0] pc, pc4, epc;
  logic pend, ferr;
  int total = 0, bad = 0;

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_br_taken(br), .i_br_target(br_t),
    .i_jump(jmp), .i_jump_target(jmp_t), .i_exc(exc), .i_epc_in(epc_in), .i_eret(eret),
    .o_pc(pc), .o_pc_plus4(pc4), .o_epc(epc), .o_redirect_pending(pend), .o_fetch_err(ferr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall = 0; br = 0; jmp = 0; exc = 0; eret = 0;
  endtask

  task automatic do_reset();
    clr();
    #2 rst_n = 0;
    #3 rst_n = 1;
  endtask

  task automatic test_reset();
    step();
    #2 rst_n = 0;
    #1;
    total++; if (pc !== 32'h3000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
    total++; if (epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=%h", epc, 32'h0); end
    total++; if (pend !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b exp=0", pend); end
    #2 rst_n = 1;
    repeat (3) step();
    total++; if (pc !== 32'h300C) begin bad++; $display("FAIL seq_pc got=%h exp=%h", pc, 32'h300C); end
    total++; if (pc4 !== 32'h3010) begin bad++; $display("FAIL seq_pc4 got=%h exp=%h", pc4, 32'h3010); end
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL seq_ferr got=%b exp=0", ferr); end
  endtask

  task automatic test_priority();
    do_reset();
    step(); step();
    total++; if (pc !== 32'h3008) begin bad++; $display("FAIL prio_start got=%h exp=%h", pc, 32'h3008); end
    jmp = 1; jmp_t = 32'h3100; br = 1; br_t = 32'h3200;
    step(); clr();
    total++; if (pc !== 32'h3100) begin bad++; $display("FAIL prio_jump got=%h exp=%h", pc, 32'h3100); end
  endtask

  task automatic test_stall_pend();
    stall = 1; br = 1; br_t = 32'h3040;
    step();
    br = 0; jmp = 1; jmp_t = 32'h3080;
    total++; if (pc !== 32'h3100 || pend !== 1'b1) begin bad++; $display("FAIL stall_c1 got=%h/%b exp=3100/1", pc, pend); end
    step();
    jmp = 0;
    step();
    total++; if (pc !== 32'h3100 || pend !== 1'b1) begin bad++; $display("FAIL stall_c3 got=%h/%b exp=3100/1", pc, pend); end
    stall = 0;
    step();
    total++; if (pc !== 32'h3080 || pend !== 1'b0) begin bad++; $display("FAIL stall_release got=%h/%b exp=3080/0", pc, pend); end
    step();
    total++; if (pc !== 32'h3084) begin bad++; $display("FAIL stall_after got=%h exp=%h", pc, 32'h3084); end
    stall = 1; jmp = 1; jmp_t = 32'h3200;
    step();
    jmp = 0; br = 1; br_t = 32'h3300;
    step();
    clr();
    step();
    total++; if (pc !== 32'h3200) begin bad++; $display("FAIL pend_no_downgrade got=%h exp=%h", pc, 32'h3200); end
    stall = 1; jmp = 1; jmp_t = 32'h3400;
    step();
    stall = 0; jmp_t = 32'h3500;
    step(); clr();
    total++; if (pc !== 32'h3500) begin bad++; $display("FAIL tie_live_wins got=%h exp=%h", pc, 32'h3500); end
  endtask

  task automatic test_exc();
    stall = 1; jmp = 1; jmp_t = 32'h3600;
    step();
    jmp = 0; exc = 1; epc_in = 32'h3017;
    step(); clr();
    total++; if (pc !== 32'h4180) begin bad++; $display("FAIL exc_pc got=%h exp=%h", pc, 32'h4180); end
    total++; if (epc !== 32'h3014) begin bad++; $display("FAIL exc_epc got=%h exp=%h", epc, 32'h3014); end
    total++; if (pend !== 1'b0) begin bad++; $display("FAIL exc_pend got=%b exp=0", pend); end
    total++; if (ferr !== 1'b1) begin bad++; $display("FAIL exc_ferr got=%b exp=1", ferr); end
    eret = 1;
    step(); clr();
    total++; if (pc !== 32'h3014) begin bad++; $display("FAIL eret_pc got=%h exp=%h", pc, 32'h3014); end
    stall = 1; eret = 1;
    step();
    eret = 0; stall = 0;
    step();
    total++; if (pc !== 32'h3014) begin bad++; $display("FAIL eret_pended got=%h exp=%h", pc, 32'h3014); end
  endtask

  task automatic test_exc_eret();
    exc = 1; epc_in = 32'h3020;
    step();
    eret = 1; epc_in = 32'h3050;
    step(); clr();
    total++; if (pc !== 32'h4180 || epc !== 32'h3050) begin bad++; $display("FAIL exc_eret got=%h/%h exp=4180/3050", pc, epc); end
  endtask

  task automatic test_fetch_err();
    jmp = 1; jmp_t = 32'h3002;
    step();
    total++; if (pc !== 32'h3002 || ferr !== 1'b1) begin bad++; $display("FAIL ferr_misalign got=%h/%b exp=3002/1", pc, ferr); end
    jmp_t = 32'h4000;
    step();
    total++; if (ferr !== 1'b1) begin bad++; $display("FAIL ferr_top got=%b exp=1", ferr); end
    jmp_t = 32'h3FFC;
    step();
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL ferr_last got=%b exp=0", ferr); end
    jmp_t = 32'h2FFC;
    step();
    total++; if (ferr !== 1'b1) begin bad++; $display("FAIL ferr_below got=%b exp=1", ferr); end
    jmp_t = 32'hFFFF_FFFC;
    step(); clr();
    total++; if (pc4 !== 32'h0) begin bad++; $display("FAIL pc4_wrap got=%h exp=0", pc4); end
    step();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL pc_wrap got=%h exp=0", pc); end
  endtask

  task automatic test_reset_mid_pend();
    stall = 1; jmp = 1; jmp_t = 32'h3700; exc = 0;
    step();
    total++; if (pend !== 1'b1) begin bad++; $display("FAIL mid_pend_set got=%b exp=1", pend); end
    #2 rst_n = 0;
    #1;
    total++; if (pc !== 32'h3000 || pend !== 1'b0 || epc !== 32'h0) begin bad++; $display("FAIL mid_reset got=%h/%b/%h exp=3000/0/0", pc, pend, epc); end
    clr();
    #2 rst_n = 1;
    step();
    total++; if (pc !== 32'h3004) begin bad++; $display("FAIL mid_reset_release got=%h exp=%h", pc, 32'h3004); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_stall_pend();
    test_exc();
    test_exc_eret();
    test_fetch_err();
    test_reset_mid_pend();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the fetch stage. Successor to the plain PC register.
- Adds a configurable width, reset vector and exception vector, a fetch stall, and prioritised next-PC selection (exception, eret, jump, branch, sequential).
- Adds an EPC register and a pending-redirect buffer, so a redirect raised during a stall is not lost.
- Flags misaligned or out-of-range fetch addresses. Sits between the branch/jump resolution logic and the instruction memory.

Parameters:
- WIDTH, 32, PC/address width in bits (≥ 16).
- RESET_VECTOR, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on an exception.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_BYTES, 4096, size of the legal fetch window in bytes.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- stall  in  1  hold PC this cycle.
- br_taken  in  1  branch resolved taken.
- br_target  in  WIDTH  branch target.
- jump  in  1  jump/jr request.
- jump_target  in  WIDTH  jump target.
- exc  in  1  exception raised.
- epc_in  in  WIDTH  PC of the faulting instruction.
- eret  in  1  return from exception.
- pc  out  WIDTH  current fetch PC (registered).
- pc_plus4  out  WIDTH  pc + 4 (combinational, modulo 2^WIDTH).
- epc  out  WIDTH  saved exception PC (registered).
- redirect_pending  out  1  buffered redirect waiting for stall release.
- fetch_err  out  1  current pc misaligned or outside the legal window.

Behaviour:
- Reset (reset=0, async, regardless of clk):
  - pc = RESET_VECTOR, epc = 0, pending buffer cleared, redirect_pending = 0.
  - Release is synchronous to the next clk edge; the first update occurs on the first rising edge with reset=1.
- Request priority, highest first: exc > eret > jump > br_taken > sequential (pc+4).
  - eret target is the current epc register value.
- exc ignores stall:
  - Next edge: pc <= EXC_VECTOR, epc <= {epc_in[WIDTH-1:2],2'b00}.
  - Pending buffer cleared.
- stall=1, no exc:
  - pc holds.
  - If any of eret/jump/br_taken is asserted, the highest-priority one (code + target) is written to the pending buffer. It overwrites an existing pending entry only if its priority ≥ the stored one. redirect_pending=1 from the next edge.
  - eret target is captured as the epc value at that time.
- stall=0, no exc:
  - Select between the pending entry and any live request. Higher priority wins; on a tie, the live request wins.
  - pc <= winner target, else pc+4.
  - Pending buffer is cleared on the same edge.
- Latency: a redirect presented with stall=0 is visible on pc one cycle later. A pended redirect is visible one cycle after the first stall=0 cycle.
- eret and exc in the same cycle: exc wins and epc is updated; the eret is dropped.
- Arithmetic: pc+4 wraps modulo 2^WIDTH. Targets are loaded unmodified; no alignment forcing on branch/jump/eret targets.
- fetch_err (combinational from pc) = 1 if:
  - pc[1:0] != 0, or
  - pc < IMEM_BASE, or
  - pc ≥ IMEM_BASE+IMEM_BYTES.
  - The unit does not raise exc itself.
- Reset mid-stall or with a pending entry: all state returns to reset values immediately; the pending request is discarded.

Test Plan:
- Reset low mid-cycle, then release → pc=32'h3000 asynchronously, epc=0; after 3 free edges pc=32'h300C, pc_plus4=32'h3010, fetch_err=0.
- At pc=32'h3008, jump=1, jump_target=32'h3100 and br_taken=1, br_target=32'h3200 in the same cycle → next pc=32'h3100.
- stall=1 for 3 cycles with br_taken=1 (target 32'h3040) in cycle 1 and jump=1 (target 32'h3080) in cycle 2 → pc holds, redirect_pending=1; first stall=0 edge: pc=32'h3080, redirect_pending=0.
- stall=1, exc=1, epc_in=32'h3017 → next pc=32'h4180 despite stall, epc=32'h3014, pending cleared. Later eret=1 → pc=32'h3014.
- Same-cycle exc=1 and eret=1, epc previously 32'h3020, epc_in=32'h3050 → pc=32'h4180, epc=32'h3050.
- jump_target=32'h3002, then jump_target=32'h4000 (IMEM_BYTES=4096) → fetch_err=1 for each; pc=32'h3FFC → fetch_err=0.
